evt_counter_7seg: RTL and testbench



---
 rtl/evcnt_pkg.sv | 42 ++++
 rtl/evt_sync_filter.sv | 53 +++++
 rtl/evt_counter_7seg.sv | 60 ++++++
 tb/tb_evt_counter_7seg.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/evcnt_pkg.sv
// Shared constants for the event counter: count width and the gfedcba segment patterns.
package evcnt_pkg;
  localparam int CNT_W = 4;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic logic [6:0] seg_decode(input logic [CNT_W-1:0] v);
    case (v)
      4'h0:    seg_decode = SEG_0;
      4'h1:    seg_decode = SEG_1;
      4'h2:    seg_decode = SEG_2;
      4'h3:    seg_decode = SEG_3;
      4'h4:    seg_decode = SEG_4;
      4'h5:    seg_decode = SEG_5;
      4'h6:    seg_decode = SEG_6;
      4'h7:    seg_decode = SEG_7;
      4'h8:    seg_decode = SEG_8;
      4'h9:    seg_decode = SEG_9;
      4'hA:    seg_decode = SEG_A;
      4'hB:    seg_decode = SEG_B;
      4'hC:    seg_decode = SEG_C;
      4'hD:    seg_decode = SEG_D;
      4'hE:    seg_decode = SEG_E;
      default: seg_decode = SEG_F;
    endcase
  endfunction
endpackage

// File: rtl/evt_sync_filter.sv
// Synchroniser for the asynchronous event level plus optional debounce filter.
// Debounce is compiled in with EVCNT_DEBOUNCE_EN; otherwise f is the synchronised level itself.
module evt_sync_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic evt_in,
  output logic f
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be 1..255");
  end

  logic [SYNC_STAGES-1:0] s;
  logic                   l;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s <= '0;
    else          s <= {s[SYNC_STAGES-2:0], evt_in};
  end

  assign l = s[SYNC_STAGES-1];

`ifdef EVCNT_DEBOUNCE_EN
  localparam logic [7:0] DC_LAST = 8'(DEBOUNCE_CYCLES - 1);
  logic [7:0] dc;

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f  <= 1'b0;
      dc <= '0;
    end else if (l != f) begin
      if (dc == DC_LAST) begin
        f  <= l;
        dc <= '0;
      end else begin
        dc <= dc + 8'd1;
      end
    end else begin
      dc <= '0;
    end
  end
`else
  // Pass-through keeps the no-debounce latency at SYNC_STAGES+1 edges.
  assign f = l;
`endif
endmodule

// File: rtl/evt_counter_7seg.sv
// Rising-edge event counter (modulo COUNT_MAX+1) with 7-segment gfedcba output.
// Optional debounce of the event input is enabled with EVCNT_DEBOUNCE_EN.
module evt_counter_7seg
  import evcnt_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_MAX       = 9,
  parameter int SEG_ACTIVE_LOW  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             evt_in,
  input  logic             clr,
  input  logic             hold,
  output logic [6:0]       seg_out,
  output logic [CNT_W-1:0] count_out,
  output logic             evt_pulse
);
  if (COUNT_MAX < 1 || COUNT_MAX > 15) begin : g_bad_cmax
    $error("COUNT_MAX must be 1..15");
  end

  localparam logic [CNT_W-1:0] CMAX = CNT_W'(COUNT_MAX);

  logic             f;
  logic             f_d;
  logic             rise;
  logic [CNT_W-1:0] count_q;

  evt_sync_filter #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_filt (
    .clk     (clk),
    .reset_n (reset_n),
    .evt_in  (evt_in),
    .f       (f)
  );

  assign rise = f & ~f_d;

  // clr wins over hold; the pulse is emitted even when the event is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_d       <= 1'b0;
      evt_pulse <= 1'b0;
      count_q   <= '0;
    end else begin
      f_d       <= f;
      evt_pulse <= rise;
      if (clr)          count_q <= '0;
      else if (hold)    count_q <= count_q;
      else if (rise)    count_q <= (count_q == CMAX) ? '0 : count_q + 4'd1;
    end
  end

  assign count_out = count_q;
  assign seg_out   = (SEG_ACTIVE_LOW != 0) ? ~seg_decode(count_q) : seg_decode(count_q);
endmodule

// File: tb/tb_evt_counter_7seg.sv
// Bench for evt_counter_7seg: two configurations checked every cycle against a behavioural model,
// plus directed checks with hand-computed values.
module tb_evt_counter_7seg;
  localparam int N = 2;
  localparam int SS [N] = '{2, 3};
  localparam int CM [N] = '{9, 15};
  localparam bit AL [N] = '{1'b0, 1'b1};
`ifdef EVCNT_DEBOUNCE_EN
  localparam int DEB = 4;
  localparam int LAT = 2 + DEB + 1;
`else
  localparam int LAT = 2 + 1;
`endif
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       reset_n, evt_in, clr, hold;
  logic [6:0] seg_o [N];
  logic [3:0] cnt_o [N];
  logic       pls_o [N];

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  evt_counter_7seg dut (
    .clk(clk), .reset_n(reset_n), .evt_in(evt_in), .clr(clr), .hold(hold),
    .seg_out(seg_o[0]), .count_out(cnt_o[0]), .evt_pulse(pls_o[0]));

  evt_counter_7seg #(.SYNC_STAGES(3), .COUNT_MAX(15), .SEG_ACTIVE_LOW(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .evt_in(evt_in), .clr(clr), .hold(hold),
    .seg_out(seg_o[1]), .count_out(cnt_o[1]), .evt_pulse(pls_o[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: input sample history, accepted level, previous accepted level, count.
  bit dly [N][4];
  bit m_f [N];
  bit m_prev [N];
  bit m_pulse [N];
  int m_run [N];
  int m_cnt [N];

  always @(posedge clk or negedge reset_n) begin : model
    bit lvl, seen, rise;
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < 4; j++) dly[i][j] = 1'b0;
        m_f[i] = 1'b0; m_prev[i] = 1'b0; m_pulse[i] = 1'b0; m_run[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        lvl = dly[i][SS[i]-1];
`ifdef EVCNT_DEBOUNCE_EN
        seen = m_f[i];
`else
        seen = lvl;
`endif
        rise = seen && !m_prev[i];
        m_pulse[i] = rise;
        m_prev[i] = seen;
        if (clr) m_cnt[i] = 0;
        else if (!hold && rise) m_cnt[i] = (m_cnt[i] + 1) % (CM[i] + 1);
`ifdef EVCNT_DEBOUNCE_EN
        if (lvl != m_f[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin m_f[i] = lvl; m_run[i] = 0; end
        end else m_run[i] = 0;
`endif
        for (int j = 3; j > 0; j--) dly[i][j] = dly[i][j-1];
        dly[i][0] = evt_in;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [6:0] es;
    for (int i = 0; i < N; i++) begin
      es = SEG_TAB[m_cnt[i]];
      if (AL[i]) es = ~es;
      check($sformatf("model_pulse%0d", i), 32'(pls_o[i]), 32'(m_pulse[i]));
      check($sformatf("model_count%0d", i), 32'(cnt_o[i]), 32'(m_cnt[i]));
      check($sformatf("model_seg%0d", i), 32'(seg_o[i]), 32'(es));
    end
    if (pls_o[0]) pulses++;
  end

  task automatic send(input int hi, input int lo);
    evt_in = 1'b1;
    repeat (hi) @(negedge clk);
    evt_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic clear_cnt();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int p0;
    reset_n = 1'b0; evt_in = 1'b0; clr = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(cnt_o[0]), 32'h0);
    check("rst_seg", 32'(seg_o[0]), 32'h3F);
    check("rst_pulse", 32'(pls_o[0]), 32'h0);
    check("rst_seg_al", 32'(seg_o[1]), 32'h40);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // first event: single pulse exactly LAT edges after the rise
    evt_in = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      check("t1_pulse_time", 32'(pls_o[0]), 32'(k == LAT));
    end
    check("t1_count", 32'(cnt_o[0]), 32'h1);
    check("t1_seg", 32'(seg_o[0]), 32'h06);
    evt_in = 1'b0;
    repeat (12) @(negedge clk);

    // ten clean pulses from zero: 1..9 then wrap to 0
    clear_cnt();
    for (int n = 1; n <= 10; n++) begin
      send(8, 8);
      check("t2_count", 32'(cnt_o[0]), 32'(n % 10));
    end
    check("t2_seg_wrap", 32'(seg_o[0]), 32'h3F);

    // 3-cycle glitch, then a 4-cycle stable high
    p0 = pulses;
    evt_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) evt_in = 1'b0;
    end
`ifdef EVCNT_DEBOUNCE_EN
    check("t3_glitch_pulses", 32'(pulses - p0), 32'h0);
    check("t3_glitch_count", 32'(cnt_o[0]), 32'h0);
`else
    check("t3_glitch_pulses", 32'(pulses - p0), 32'h1);
    check("t3_glitch_count", 32'(cnt_o[0]), 32'h1);
`endif
    evt_in = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("t3_stable_pulse", 32'(pls_o[0]), 32'(k == LAT));
      if (k == 4) evt_in = 1'b0;
    end
    repeat (8) @(negedge clk);

    // clr coincident with the pulse edge
    evt_in = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == LAT - 1) clr = 1'b1;
    end
    clr = 1'b0;
    check("t4_clr_pulse", 32'(pls_o[0]), 32'h1);
    check("t4_clr_count", 32'(cnt_o[0]), 32'h0);
    evt_in = 1'b0;
    repeat (10) @(negedge clk);

    // hold: three pulses emitted, none counted
    send(8, 8);
    hold = 1'b1;
    p0 = pulses;
    repeat (3) send(8, 8);
    hold = 1'b0;
    check("t4_hold_pulses", 32'(pulses - p0), 32'h3);
    check("t4_hold_count", 32'(cnt_o[0]), 32'h1);

    // asynchronous reset mid-count, released with evt_in high
    clear_cnt();
    repeat (5) send(8, 8);
    check("t5_pre_count", 32'(cnt_o[0]), 32'h5);
    check("t5_pre_seg", 32'(seg_o[0]), 32'h6D);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_count", 32'(cnt_o[0]), 32'h0);
    check("t5_async_seg", 32'(seg_o[0]), 32'h3F);
    check("t5_async_pulse", 32'(pls_o[0]), 32'h0);
    check("t5_async_seg_al", 32'(seg_o[1]), 32'h40);
    evt_in = 1'b1;
    @(negedge clk);
    #3 reset_n = 1'b1;
    p0 = pulses;
    repeat (LAT + 6) @(negedge clk);
    check("t5_release_count", 32'(cnt_o[0]), 32'h1);
    check("t5_release_pulses", 32'(pulses - p0), 32'h1);
    evt_in = 1'b0;
    repeat (10) @(negedge clk);

    // COUNT_MAX=15, active-low segments: reach F then wrap
    clear_cnt();
    repeat (15) send(8, 8);
    check("t6_count_f", 32'(cnt_o[1]), 32'hF);
    check("t6_seg_f_al", 32'(seg_o[1]), 32'h0E);
    check("t6_count_dflt", 32'(cnt_o[0]), 32'h5);
    check("t6_seg_dflt", 32'(seg_o[0]), 32'h6D);
    send(8, 8);
    check("t6_wrap_count", 32'(cnt_o[1]), 32'h0);
    check("t6_wrap_seg_al", 32'(seg_o[1]), 32'h40);
    check("t6_next_count", 32'(cnt_o[0]), 32'h6);
    check("t6_next_seg", 32'(seg_o[0]), 32'h7D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
